traffic_phase_ctrl: RTL and testbench

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

---
 rtl/traffic_pkg.sv | 21 ++
 rtl/phase_timer.sv | 29 ++
 rtl/traffic_phase_ctrl.sv | 172 +++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase controllers: phase encoding and
// the legality rule for phase durations against a timer width.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2,
    ST_FLASH   = 2'd3
  } phase_t;

  localparam int MIN_DURATION = 1;
  localparam int MAX_CNT_W    = 31;

  // A duration is loaded as DURATION-1, so it must be nonzero and fit the counter.
  function automatic bit duration_fits(int dur, int cnt_w);
    return (cnt_w >= 1) && (cnt_w <= MAX_CNT_W) && (dur >= MIN_DURATION) &&
           (longint'(dur) < (longint'(1) << cnt_w));
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter advanced by the tick strobe; expire flags a tick
// arriving while the count is already at zero.
module phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = tick && (count == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Intersection phase sequencer: round-robin green service with rest-in-green,
// fixed yellow and all-red clearance, and a flashing-yellow override.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_ALL_RED | every direction red; clearance before choosing next owner
// ST_GREEN   | active_dir green; may rest here while it is the only demand
// ST_YELLOW  | active_dir yellow; completion pulses phase_done
// ST_FLASH   | all reds/greens off, all yellows blink on each tick
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIR      = 4,
  parameter int CNT_W        = 8,
  parameter int GREEN_TICKS  = 20,
  parameter int YELLOW_TICKS = 4,
  parameter int ALLRED_TICKS = 2,
  localparam int DIR_W       = $clog2(NUM_DIR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [NUM_DIR-1:0] req,
  input  logic               flash_en,
  output logic [NUM_DIR-1:0] red,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] green,
  output logic [DIR_W-1:0]   active_dir,
  output logic               phase_done
);

  if (NUM_DIR < 2 || NUM_DIR > 8) begin : g_bad_num_dir
    $error("NUM_DIR must be in 2..8");
  end
  if (!duration_fits(GREEN_TICKS, CNT_W)) begin : g_bad_green
    $error("GREEN_TICKS must be in 1..2**CNT_W-1");
  end
  if (!duration_fits(YELLOW_TICKS, CNT_W)) begin : g_bad_yellow
    $error("YELLOW_TICKS must be in 1..2**CNT_W-1");
  end
  if (!duration_fits(ALLRED_TICKS, CNT_W)) begin : g_bad_allred
    $error("ALLRED_TICKS must be in 1..2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TICKS - 1);

  phase_t             state, state_next;
  logic [DIR_W-1:0]   dir_next, rr_pick, cand;
  logic               found;
  logic [NUM_DIR-1:0] own_mask;
  logic               rest_in_green;
  logic               done_next;
  logic               tgl_q, tgl_next;
  logic               timer_load, expire;
  logic [CNT_W-1:0]   timer_val;
  logic [NUM_DIR-1:0] red_next, yellow_next, green_next;

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (ALLRED_LOAD)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .load     (timer_load),
    .load_val (timer_val),
    .expire   (expire)
  );

  // First requesting direction after the current owner, wrapping to the owner itself.
  always_comb begin
    rr_pick = DIR_W'((int'(active_dir) + 1) % NUM_DIR);
    cand    = '0;
    found   = 1'b0;
    for (int i = 1; i <= NUM_DIR; i++) begin
      cand = DIR_W'((int'(active_dir) + i) % NUM_DIR);
      if (!found && req[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    own_mask             = '0;
    own_mask[active_dir] = 1'b1;
    rest_in_green        = req[active_dir] && ((req & ~own_mask) == '0);
  end

  always_comb begin
    state_next = state;
    dir_next   = active_dir;
    done_next  = 1'b0;
    if (flash_en) begin
      state_next = ST_FLASH;
    end else if (state == ST_FLASH) begin
      state_next = ST_ALL_RED;
    end else if (expire) begin
      case (state)
        ST_ALL_RED: begin
          state_next = ST_GREEN;
          dir_next   = rr_pick;
        end
        ST_GREEN: begin
          if (!rest_in_green) state_next = ST_YELLOW;
        end
        ST_YELLOW: begin
          state_next = ST_ALL_RED;
          done_next  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    timer_load = (state_next != state) && (state_next != ST_FLASH);
    case (state_next)
      ST_GREEN:  timer_val = GREEN_LOAD;
      ST_YELLOW: timer_val = YELLOW_LOAD;
      default:   timer_val = ALLRED_LOAD;
    endcase
  end

  // The blink phase starts from off on entry, so the entering tick lights it.
  assign tgl_next = (state_next == ST_FLASH) ?
                    (((state == ST_FLASH) ? tgl_q : 1'b0) ^ tick) : 1'b0;

  always_comb begin
    red_next    = '1;
    yellow_next = '0;
    green_next  = '0;
    case (state_next)
      ST_GREEN: begin
        green_next[dir_next] = 1'b1;
        red_next[dir_next]   = 1'b0;
      end
      ST_YELLOW: begin
        yellow_next[dir_next] = 1'b1;
        red_next[dir_next]    = 1'b0;
      end
      ST_FLASH: begin
        red_next    = '0;
        yellow_next = {NUM_DIR{tgl_next}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_ALL_RED;
      active_dir <= DIR_W'(NUM_DIR - 1);
      tgl_q      <= 1'b0;
      red        <= '1;
      yellow     <= '0;
      green      <= '0;
      phase_done <= 1'b0;
    end else begin
      state      <= state_next;
      active_dir <= dir_next;
      tgl_q      <= tgl_next;
      red        <= red_next;
      yellow     <= yellow_next;
      green      <= green_next;
      phase_done <= done_next;
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: fixed vector table, directed
// corner sequences, and randomized traffic against a tick-counting model.
module tb_traffic_phase_ctrl;

  localparam int N  = 4;
  localparam int GT = 3;
  localparam int YT = 2;
  localparam int AT = 1;

  logic       clk = 1'b0;
  logic       reset, tick, flash_en;
  logic [3:0] req;
  logic [3:0] red, yellow, green;
  logic [1:0] active_dir;
  logic       phase_done;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .NUM_DIR      (N),
    .CNT_W        (8),
    .GREEN_TICKS  (GT),
    .YELLOW_TICKS (YT),
    .ALLRED_TICKS (AT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .req        (req),
    .flash_en   (flash_en),
    .red        (red),
    .yellow     (yellow),
    .green      (green),
    .active_dir (active_dir),
    .phase_done (phase_done)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: phase letter, ticks remaining in the phase, owner, pulse, blink level.
  byte m_mode;
  int  m_left;
  int  m_dir;
  bit  m_done;
  bit  m_fl;

  typedef struct {
    bit         tk;
    bit         fl;
    logic [3:0] rq;
    byte        ph;
    int         dir;
    bit         done;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mkv(byte ph, int dir, bit done);
    vec_t v;
    v.tk = 1'b1; v.fl = 1'b0; v.rq = 4'h0;
    v.ph = ph; v.dir = dir; v.done = done;
    return v;
  endfunction

  function automatic logic [14:0] pack_exp(byte ph, int dir, bit done, bit fl);
    logic [3:0] r, y, g;
    logic [1:0] d;
    d = dir[1:0]; r = 4'hF; y = 4'h0; g = 4'h0;
    if (ph == "G") begin
      g[d] = 1'b1; r[d] = 1'b0;
    end else if (ph == "Y") begin
      y[d] = 1'b1; r[d] = 1'b0;
    end else if (ph == "F") begin
      r = 4'h0; y = {4{fl}};
    end
    return {r, y, g, d, done};
  endfunction

  function automatic logic [14:0] dut_out();
    return {red, yellow, green, active_dir, phase_done};
  endfunction

  function automatic void check(string nm, logic [14:0] act, logic [14:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got r/y/g/dir/done=%b/%b/%b/%0d/%b want %b/%b/%b/%0d/%b", nm,
               act[14:11], act[10:7], act[6:3], act[2:1], act[0],
               exp_v[14:11], exp_v[10:7], exp_v[6:3], exp_v[2:1], exp_v[0]);
    end
  endfunction

  function automatic void check_int(string nm, int act, int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp_v);
    end
  endfunction

  function automatic int rr_pick(logic [3:0] rq);
    for (int k = 1; k <= N; k++) begin
      int d;
      d = (m_dir + k) % N;
      if (rq[d[1:0]]) return d;
    end
    return (m_dir + 1) % N;
  endfunction

  task automatic model_step(bit rs, bit tk, bit fl, logic [3:0] rq);
    if (rs) begin
      m_mode = "R"; m_left = AT; m_dir = N - 1; m_done = 1'b0; m_fl = 1'b0;
      return;
    end
    m_done = 1'b0;
    if (fl) begin
      if (m_mode != "F") begin
        m_mode = "F"; m_fl = tk;
      end else if (tk) begin
        m_fl = !m_fl;
      end
    end else if (m_mode == "F") begin
      m_mode = "R"; m_left = AT; m_fl = 1'b0;
    end else if (tk) begin
      m_left--;
      if (m_left == 0) begin
        if (m_mode == "R") begin
          m_dir = rr_pick(rq); m_mode = "G"; m_left = GT;
        end else if (m_mode == "G") begin
          if (rq[m_dir[1:0]] && ((rq & ~(4'b0001 << m_dir)) == 4'b0000)) m_left = 1;
          else begin
            m_mode = "Y"; m_left = YT;
          end
        end else if (m_mode == "Y") begin
          m_mode = "R"; m_left = AT; m_done = 1'b1;
        end
      end
    end
  endtask

  // Apply one cycle of inputs, then compare the registered outputs with the model.
  task automatic drive(bit rs, bit tk, bit fl, logic [3:0] rq);
    reset = rs; tick = tk; flash_en = fl; req = rq;
    @(posedge clk);
    model_step(rs, tk, fl, rq);
    #1;
    cyc++;
    check($sformatf("model@%0d", cyc), dut_out(), pack_exp(m_mode, m_dir, m_done, m_fl));
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0);
    check("reset_state", dut_out(), {4'hF, 4'h0, 4'h0, 2'd3, 1'b0});
  endtask

  initial begin
    int   served[$];
    logic [3:0] prev_g;
    int   bad_green, gcnt, ycnt, rcnt, dcnt;
    logic fl_r;
    logic [3:0] rq_r;

    reset = 1'b1; tick = 1'b0; flash_en = 1'b0; req = 4'h0;

    // Rotation with no demand: row i holds the outputs seen in cycle i+1.
    tbl[0]  = mkv("G", 0, 0); tbl[1]  = mkv("G", 0, 0); tbl[2]  = mkv("G", 0, 0);
    tbl[3]  = mkv("Y", 0, 0); tbl[4]  = mkv("Y", 0, 0); tbl[5]  = mkv("R", 0, 1);
    tbl[6]  = mkv("G", 1, 0); tbl[7]  = mkv("G", 1, 0); tbl[8]  = mkv("G", 1, 0);
    tbl[9]  = mkv("Y", 1, 0); tbl[10] = mkv("Y", 1, 0); tbl[11] = mkv("R", 1, 1);
    tbl[12] = mkv("G", 2, 0); tbl[13] = mkv("G", 2, 0); tbl[14] = mkv("G", 2, 0);
    tbl[15] = mkv("Y", 2, 0); tbl[16] = mkv("Y", 2, 0); tbl[17] = mkv("R", 2, 1);
    tbl[18] = mkv("G", 3, 0); tbl[19] = mkv("G", 3, 0); tbl[20] = mkv("G", 3, 0);
    tbl[21] = mkv("Y", 3, 0); tbl[22] = mkv("Y", 3, 0); tbl[23] = mkv("R", 3, 1);
    tbl[24] = mkv("G", 0, 0);

    do_reset();
    for (int i = 0; i < 25; i++) begin
      drive(1'b0, tbl[i].tk, tbl[i].fl, tbl[i].rq);
      check($sformatf("vec%0d", i), dut_out(), pack_exp(tbl[i].ph, tbl[i].dir, tbl[i].done, 1'b0));
    end

    // Rest in green on dir0, released by dir2 demand at cycle 10.
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      drive(1'b0, 1'b1, 1'b0, (c >= 10) ? 4'b0101 : 4'b0001);
      if (c <= 9)       check($sformatf("rest@%0d", c + 1), dut_out(), pack_exp("G", 0, 0, 0));
      else if (c <= 11) check($sformatf("rest@%0d", c + 1), dut_out(), pack_exp("Y", 0, 0, 0));
      else if (c == 12) check("rest@13", dut_out(), pack_exp("R", 0, 1, 0));
      else              check("rest@14", dut_out(), pack_exp("G", 2, 0, 0));
    end

    // Only dirs 1 and 3 request: they alternate, 0 and 2 never go green.
    do_reset();
    prev_g = 4'h0; bad_green = 0;
    for (int c = 0; c <= 24; c++) begin
      drive(1'b0, 1'b1, 1'b0, 4'b1010);
      if (green[0] || green[2]) bad_green++;
      if (green != 4'h0 && green != prev_g) begin
        for (int d = 0; d < N; d++) if (green[d]) served.push_back(d);
      end
      prev_g = green;
    end
    check_int("rr_no_green_0_2", bad_green, 0);
    check_int("rr_served_count", served.size(), 5);
    if (served.size() >= 4) begin
      check_int("rr_order0", served[0], 1);
      check_int("rr_order1", served[1], 3);
      check_int("rr_order2", served[2], 1);
      check_int("rr_order3", served[3], 3);
    end

    // Flash during dir0 green, then release.
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      drive(1'b0, 1'b1, (c >= 2 && c <= 5), 4'h0);
      case (c)
        0, 1:    check($sformatf("flash@%0d", c + 1), dut_out(), pack_exp("G", 0, 0, 0));
        2, 4:    check($sformatf("flash@%0d", c + 1), dut_out(), pack_exp("F", 0, 0, 1));
        3, 5:    check($sformatf("flash@%0d", c + 1), dut_out(), pack_exp("F", 0, 0, 0));
        6:       check("flash@7", dut_out(), pack_exp("R", 0, 0, 0));
        default: check("flash@8", dut_out(), pack_exp("G", 1, 0, 0));
      endcase
    end

    // Tick every third cycle stretches every phase threefold; reset lands mid-yellow.
    do_reset();
    gcnt = 0; ycnt = 0; rcnt = 0; dcnt = 0;
    for (int c = 0; c <= 29; c++) begin
      drive(1'b0, (c % 3 == 0), 1'b0, 4'h0);
      if (green == 4'b0001) gcnt++;
      if (yellow == 4'b0001) ycnt++;
      if (red == 4'hF && active_dir == 2'd0) rcnt++;
      if (phase_done) dcnt++;
    end
    check_int("slow_green_len", gcnt, 3 * GT);
    check_int("slow_yellow_len", ycnt, 3 * YT);
    check_int("slow_allred_len", rcnt, 3 * AT);
    check_int("slow_done_pulses", dcnt, 1);
    check("slow_yellow_dir1", dut_out(), pack_exp("Y", 1, 0, 0));
    drive(1'b1, 1'b0, 1'b0, 4'h0);
    check("reset_mid_yellow", dut_out(), {4'hF, 4'h0, 4'h0, 2'd3, 1'b0});

    // Randomized traffic against the model.
    do_reset();
    fl_r = 1'b0; rq_r = 4'h0;
    for (int c = 0; c < 4000; c++) begin
      if (!fl_r && $urandom_range(0, 79) == 0) fl_r = 1'b1;
      else if (fl_r && $urandom_range(0, 7) == 0) fl_r = 1'b0;
      if ($urandom_range(0, 3) == 0) rq_r = 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) != 0), fl_r, rq_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
